bsg_array_piso_skip: RTL
========================

Name: bsg_array_piso_skip

Overview:
Downstream consumer of the static array concentrator. It takes one concentrated array of els_p elements, each width_p bits, plus a per-element live mask. It then emits the live elements one per cycle, lowest index first, on a ready/valid output, skipping masked-off slots. It is a one-entry buffered parallel-in/serial-out stage that sits between the concentrator and a narrow link or FIFO.

Parameters:
width_p, 8, bits per array element
els_p, 32, elements per input array (els_p*width_p = 256 matches concentrator output)
lg_els_lp, $clog2(els_p), derived; width of index output (min 1)

Ports:
clk_i  input  1  clock; all state updates on rising edge
reset_i  input  1  synchronous, active-high reset
valid_i  input  1  input array valid
data_i  input  els_p*width_p  concentrated array; element k = data_i[k*width_p +: width_p]
mask_i  input  els_p  live mask; bit k=1 means element k is emitted
ready_and_o  output  1  block can accept an array this cycle
valid_o  output  1  output element valid
data_o  output  width_p  current output element
idx_o  output  lg_els_lp  array index of data_o
last_o  output  1  data_o is the final live element of its array
yumi_i  input  1  downstream consumes data_o (only legal when valid_o=1)

Behaviour:
- One clock (clk_i); reset_i is synchronous and active-high.
- State: data_r (els_p*width_p), rem_r (els_p remaining-live mask). Block is busy iff rem_r != 0; no separate FSM register needed. States: EMPTY (rem_r==0), SEND (rem_r!=0).
- Reset: rem_r <= 0. data_r is don't-care. Outputs after reset: valid_o=0, last_o=0, ready_and_o=1. data_o/idx_o are don't-care while valid_o=0; verification must not check them then.
- valid_o = (rem_r != 0).
- idx_o = index of the lowest set bit of rem_r. data_o = data_r element idx_o (combinational mux from registers).
- last_o = valid_o & (rem_r has exactly one bit set).
- ready_and_o = ~valid_o | (yumi_i & last_o). This is combinational from yumi_i and allows back-to-back arrays with no bubble.
- Accept: valid_i & ready_and_o. On accept, data_r <= data_i and rem_r <= mask_i.
- Consume: yumi_i (requires valid_o). On consume without simultaneous accept, rem_r <= rem_r with the lowest set bit cleared.
- Consume of the last element together with accept: the new array wins. rem_r <= mask_i, data_r <= data_i.
- Latency: array accepted at cycle N drives its first element with valid_o=1 at cycle N+1. A fully live array drains in els_p consecutive cycles when yumi_i is held high.
- Zero mask: an array with mask_i=0 is accepted (handshake completes) and dropped. rem_r stays 0, no output is produced, and ready_and_o stays 1 next cycle.
- Element order is strictly ascending index. Each live element is emitted exactly once. Masked elements are never emitted.
- Stall: while yumi_i=0, data_o, idx_o, last_o and valid_o hold stable.
- Assertions (sim only): yumi_i & ~valid_o is an error. While valid_i=1 & ready_and_o=0, the upstream must hold data_i/mask_i stable (checked, not enforced).
- Reset mid-operation: when reset_i=1, the in-flight array is discarded. Next cycle valid_o=0 and ready_and_o=1. Any valid_i in the reset cycle is ignored.
- yumi_i is not required to be independent of valid_o, but ready_and_o must not combinationally depend on valid_i (no loop).

Test Plan:
- Reset, then valid_i=1, mask_i=32'h0000_0005, element0=8'hA0, element2=8'hA2, yumi_i=1 -> cycle+1: data_o=A0 idx_o=0 last_o=0; cycle+2: data_o=A2 idx_o=2 last_o=1; cycle+3: valid_o=0.
- Full mask 32'hFFFF_FFFF, element k = k, yumi_i=1 -> 32 consecutive outputs with data_o=idx_o=0..31, last_o only on idx 31, ready_and_o=1 only in that last cycle.
- Back-to-back: array A mask=32'h8000_0000 (element31=8'h5A) then array B mask=32'h1 (element0=8'hC3) presented continuously -> outputs 5A (last_o=1) then C3 on the next cycle with no bubble.
- Zero mask: mask_i=0 accepted -> valid_o stays 0 and ready_and_o=1 every cycle. A following mask=32'h2 array emits idx_o=1 one cycle after its acceptance.
- Backpressure: mask=32'h0000_0300, yumi_i=0 for 5 cycles -> data_o/idx_o=8 held stable and ready_and_o=0. Then yumi_i=1 -> idx 8 then idx 9 with last_o=1.
- Reset mid-drain: full-mask array, assert reset_i after 3 outputs -> next cycle valid_o=0, ready_and_o=1. A new mask=32'h1 array then outputs only its element 0.

Source files
------------

// File: rtl/bsg_array_piso_skip.sv
// Parallel-in/serial-out stage. It accepts one array plus a live mask and
// emits the live elements one per cycle, lowest index first, skipping dead slots.
module bsg_array_piso_skip #(
    parameter int width_p   = 8,
    parameter int els_p     = 32,
    parameter int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     valid_i,
    input  logic [els_p*width_p-1:0] data_i,
    input  logic [els_p-1:0]         mask_i,
    output logic                     ready_and_o,
    output logic                     valid_o,
    output logic [width_p-1:0]       data_o,
    output logic [lg_els_lp-1:0]     idx_o,
    output logic                     last_o,
    input  logic                     yumi_i
);

    localparam logic [els_p-1:0] one_lp = {{(els_p-1){1'b0}}, 1'b1};

    logic [els_p*width_p-1:0] data_q, data_d;
    logic [els_p-1:0]         rem_q, rem_d;
    logic [els_p-1:0]         rem_minus_one;
    logic                     accept;

    assign rem_minus_one = rem_q - one_lp;

    // rem_q & (rem_q - 1) clears the lowest set bit; zero result means one bit left
    assign valid_o     = |rem_q;
    assign last_o      = valid_o & ~|(rem_q & rem_minus_one);
    assign ready_and_o = ~valid_o | (yumi_i & last_o);
    assign accept      = valid_i & ready_and_o;

    always_comb begin
        idx_o = '0;
        for (int k = els_p - 1; k >= 0; k--) begin
            if (rem_q[k]) idx_o = lg_els_lp'(k);
        end
    end

    assign data_o = data_q[idx_o*width_p +: width_p];

    always_comb begin
        rem_d  = rem_q;
        data_d = data_q;
        if (accept) begin
            rem_d  = mask_i;
            data_d = data_i;
        end else if (yumi_i) begin
            rem_d  = rem_q & rem_minus_one;
        end
    end

    // Only the live mask needs reset; the data register is don't-care when empty
    always_ff @(posedge clk_i) begin
        if (reset_i) rem_q <= '0;
        else         rem_q <= rem_d;
        data_q <= data_d;
    end

`ifndef SYNTHESIS
    logic                     hold_q;
    logic [els_p*width_p-1:0] data_prev_q;
    logic [els_p-1:0]         mask_prev_q;

    always_ff @(posedge clk_i) begin
        hold_q      <= ~reset_i & valid_i & ~ready_and_o;
        data_prev_q <= data_i;
        mask_prev_q <= mask_i;
        if (!reset_i) begin
            assert (!(yumi_i && !valid_o))
                else $error("yumi_i asserted while valid_o is low");
            assert (!(hold_q && valid_i && (data_i != data_prev_q || mask_i != mask_prev_q)))
                else $error("upstream changed data_i/mask_i while stalled");
        end
    end
`endif

endmodule
